// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared processor constants and fetch FSM encoding
package instruction_fetch_unit_pkg;

    localparam int          INST_W = 16;
    localparam logic [15:0] PC_INC = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_VALID = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction memory request/response bus
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic              out_MemReq;
    logic [15:0]       out_MemAddr;
    logic              in_MemReady;
    logic [INST_W-1:0] in_MemData;

    modport master (
        output out_MemReq,
        output out_MemAddr,
        input  in_MemReady,
        input  in_MemData
    );

    modport slave (
        input  out_MemReq,
        input  out_MemAddr,
        output in_MemReady,
        output in_MemData
    );
endinterface

// File: rtl/instruction_fetch_unit_pc_register.sv
// rtl/instruction_fetch_unit_pc_register.sv - program counter with load and increment
module pc_register
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        inc_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Load takes priority over increment; increment wraps naturally at 2^16.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch FSM with redirect drain and timeout
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_Redirect,
    input  logic [15:0]                in_RedirectPC,
    instruction_fetch_unit_if.master   mem,
    output logic [INST_W-1:0]          out_Inst,
    output logic                       out_InstValid,
    input  logic                       in_InstAccept,
    output logic                       out_IRWrite,
    output logic [15:0]                out_PC,
    output logic                       out_FetchErr,
    output logic [15:0]                out_FetchCount
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [15:0]       count_q, count_d;
    logic [15:0]       drain_addr_q, drain_addr_d;
    logic [7:0]        wait_q, wait_d;
    logic              err_q, err_d;
    logic              pc_load;
    logic              pc_inc;
    logic [15:0]       pc;
    logic [7:0]        wait_next;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (pc_load),
        .load_val_i (in_RedirectPC),
        .inc_i      (pc_inc),
        .pc_o       (pc)
    );

    assign wait_next = wait_q + 8'd1;

    // Next-state and output decode; the drain address remembers the request
    // still outstanding at the memory after a redirect moved the PC away.
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        count_d       = count_q;
        drain_addr_d  = drain_addr_q;
        wait_d        = wait_q;
        err_d         = err_q;
        pc_load       = 1'b0;
        pc_inc        = 1'b0;
        mem.out_MemReq  = 1'b0;
        mem.out_MemAddr = pc;
        out_InstValid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pc_load = in_Redirect;
                wait_d  = 8'd0;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem.out_MemReq = 1'b1;
                if (in_Redirect) begin
                    pc_load = 1'b1;
                    wait_d  = 8'd0;
                    if (mem.in_MemReady) begin
                        state_d = ST_FETCH;
                    end else begin
                        drain_addr_d = pc;
                        state_d      = ST_DRAIN;
                    end
                end else if (mem.in_MemReady) begin
                    inst_d  = mem.in_MemData;
                    wait_d  = 8'd0;
                    state_d = ST_VALID;
                end else begin
                    wait_d = wait_next;
                    if (wait_next == TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DRAIN: begin
                mem.out_MemReq  = 1'b1;
                mem.out_MemAddr = drain_addr_q;
                pc_load         = in_Redirect;
                if (mem.in_MemReady) begin
                    wait_d  = 8'd0;
                    state_d = ST_FETCH;
                end else begin
                    wait_d = wait_next;
                    if (wait_next == TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_VALID: begin
                out_InstValid = 1'b1;
                if (in_Redirect) begin
                    pc_load = 1'b1;
                    wait_d  = 8'd0;
                    state_d = ST_FETCH;
                end else if (in_InstAccept) begin
                    pc_inc  = 1'b1;
                    count_d = count_q + 16'd1;
                    wait_d  = 8'd0;
                    state_d = ST_FETCH;
                end
            end
            ST_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            inst_q       <= '0;
            count_q      <= 16'd0;
            drain_addr_q <= 16'd0;
            wait_q       <= 8'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            count_q      <= count_d;
            drain_addr_q <= drain_addr_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
        end
    end

    assign out_IRWrite    = out_InstValid & in_InstAccept & ~in_Redirect;
    assign out_Inst       = inst_q;
    assign out_PC         = pc;
    assign out_FetchErr   = err_q;
    assign out_FetchCount = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_Redirect;
    logic [15:0] in_RedirectPC;
    logic [15:0] out_Inst;
    logic        out_InstValid;
    logic        in_InstAccept;
    logic        out_IRWrite;
    logic [15:0] out_PC;
    logic        out_FetchErr;
    logic [15:0] out_FetchCount;

    logic        rst2;
    logic [15:0] inst2;
    logic        valid2;
    logic        irw2;
    logic [15:0] pc2;
    logic        err2;
    logic [15:0] count2;

    int checks = 0;
    int passes = 0;
    int irw_pulses;

    instruction_fetch_unit_if mem_bus ();
    instruction_fetch_unit_if mem_bus2 ();

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_Redirect    (in_Redirect),
        .in_RedirectPC  (in_RedirectPC),
        .mem            (mem_bus),
        .out_Inst       (out_Inst),
        .out_InstValid  (out_InstValid),
        .in_InstAccept  (in_InstAccept),
        .out_IRWrite    (out_IRWrite),
        .out_PC         (out_PC),
        .out_FetchErr   (out_FetchErr),
        .out_FetchCount (out_FetchCount)
    );

    instruction_fetch_unit #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (8'd4)
    ) dut_to (
        .CLK            (CLK),
        .RST            (rst2),
        .in_Redirect    (1'b0),
        .in_RedirectPC  (16'h0000),
        .mem            (mem_bus2),
        .out_Inst       (inst2),
        .out_InstValid  (valid2),
        .in_InstAccept  (1'b0),
        .out_IRWrite    (irw2),
        .out_PC         (pc2),
        .out_FetchErr   (err2),
        .out_FetchCount (count2)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        rst2 = 1'b0;
        in_Redirect = 1'b0;
        in_RedirectPC = 16'h0000;
        in_InstAccept = 1'b0;
        mem_bus.in_MemReady = 1'b0;
        mem_bus.in_MemData = 16'h0000;
        mem_bus2.in_MemReady = 1'b0;
        mem_bus2.in_MemData = 16'h0000;
        tick();
        tick();
        checks++; if (mem_bus.out_MemReq !== 1'b0) $display("FAIL reset_memreq: got %b want 0", mem_bus.out_MemReq); else passes++;
        checks++; if (out_InstValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_InstValid); else passes++;
        checks++; if (out_IRWrite !== 1'b0) $display("FAIL reset_irwrite: got %b want 0", out_IRWrite); else passes++;
        checks++; if (out_PC !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", out_PC); else passes++;
        checks++; if (out_Inst !== 16'h0000) $display("FAIL reset_inst: got %h want 0000", out_Inst); else passes++;
        checks++; if (out_FetchCount !== 16'h0000) $display("FAIL reset_count: got %h want 0000", out_FetchCount); else passes++;
        checks++; if (out_FetchErr !== 1'b0) $display("FAIL reset_err: got %b want 0", out_FetchErr); else passes++;
        RST = 1'b1;
        settle();
        checks++; if (mem_bus.out_MemReq !== 1'b0) $display("FAIL idle_memreq: got %b want 0", mem_bus.out_MemReq); else passes++;
        tick();
        checks++; if (mem_bus.out_MemReq !== 1'b1) $display("FAIL first_fetch_req: got %b want 1", mem_bus.out_MemReq); else passes++;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_addr;
        mem_bus.in_MemReady = 1'b1;
        in_InstAccept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_addr = 16'(2 * i);
            mem_bus.in_MemData = 16'hA000 | exp_addr;
            settle();
            checks++; if (mem_bus.out_MemAddr !== exp_addr) $display("FAIL seq_addr%0d: got %h want %h", i, mem_bus.out_MemAddr, exp_addr); else passes++;
            checks++; if (out_InstValid !== 1'b0) $display("FAIL seq_valid_fetch%0d: got %b want 0", i, out_InstValid); else passes++;
            tick();
            checks++; if (out_Inst !== (16'hA000 | exp_addr)) $display("FAIL seq_inst%0d: got %h want %h", i, out_Inst, 16'hA000 | exp_addr); else passes++;
            checks++; if (out_IRWrite !== 1'b1) $display("FAIL seq_irwrite%0d: got %b want 1", i, out_IRWrite); else passes++;
            checks++; if (mem_bus.out_MemReq !== 1'b0) $display("FAIL seq_req_valid%0d: got %b want 0", i, mem_bus.out_MemReq); else passes++;
            tick();
        end
        checks++; if (out_FetchCount !== 16'd3) $display("FAIL seq_count: got %0d want 3", out_FetchCount); else passes++;
        checks++; if (out_PC !== 16'h0006) $display("FAIL seq_pc: got %h want 0006", out_PC); else passes++;
    endtask

    task automatic test_wait_hold();
        mem_bus.in_MemReady = 1'b0;
        in_InstAccept = 1'b0;
        irw_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (mem_bus.out_MemReq !== 1'b1 || mem_bus.out_MemAddr !== 16'h0006) $display("FAIL wait_req%0d: got %b/%h want 1/0006", i, mem_bus.out_MemReq, mem_bus.out_MemAddr); else passes++;
            tick();
        end
        mem_bus.in_MemReady = 1'b1;
        mem_bus.in_MemData = 16'h1234;
        tick();
        mem_bus.in_MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (out_InstValid !== 1'b1 || out_Inst !== 16'h1234) $display("FAIL hold%0d: got %b/%h want 1/1234", i, out_InstValid, out_Inst); else passes++;
            if (out_IRWrite === 1'b1) irw_pulses++;
            tick();
        end
        in_InstAccept = 1'b1;
        settle();
        checks++; if (out_InstValid !== 1'b1 || out_Inst !== 16'h1234) $display("FAIL hold_accept: got %b/%h want 1/1234", out_InstValid, out_Inst); else passes++;
        if (out_IRWrite === 1'b1) irw_pulses++;
        tick();
        in_InstAccept = 1'b0;
        settle();
        if (out_IRWrite === 1'b1) irw_pulses++;
        checks++; if (irw_pulses !== 1) $display("FAIL irwrite_pulses: got %0d want 1", irw_pulses); else passes++;
        checks++; if (out_FetchCount !== 16'd4) $display("FAIL wait_count: got %0d want 4", out_FetchCount); else passes++;
        checks++; if (mem_bus.out_MemAddr !== 16'h0008) $display("FAIL wait_next_addr: got %h want 0008", mem_bus.out_MemAddr); else passes++;
    endtask

    task automatic test_redirect_fetch();
        in_Redirect = 1'b1;
        in_RedirectPC = 16'h0040;
        settle();
        checks++; if (mem_bus.out_MemAddr !== 16'h0008) $display("FAIL rf_pre_addr: got %h want 0008", mem_bus.out_MemAddr); else passes++;
        tick();
        in_Redirect = 1'b0;
        settle();
        checks++; if (mem_bus.out_MemReq !== 1'b1 || mem_bus.out_MemAddr !== 16'h0008) $display("FAIL drain_addr: got %b/%h want 1/0008", mem_bus.out_MemReq, mem_bus.out_MemAddr); else passes++;
        checks++; if (out_PC !== 16'h0040) $display("FAIL drain_pc: got %h want 0040", out_PC); else passes++;
        tick();
        mem_bus.in_MemReady = 1'b1;
        mem_bus.in_MemData = 16'hDEAD;
        settle();
        checks++; if (mem_bus.out_MemAddr !== 16'h0008) $display("FAIL drain_addr2: got %h want 0008", mem_bus.out_MemAddr); else passes++;
        tick();
        mem_bus.in_MemReady = 1'b0;
        settle();
        checks++; if (mem_bus.out_MemReq !== 1'b1 || mem_bus.out_MemAddr !== 16'h0040) $display("FAIL rf_new_addr: got %b/%h want 1/0040", mem_bus.out_MemReq, mem_bus.out_MemAddr); else passes++;
        checks++; if (out_InstValid !== 1'b0 || out_Inst !== 16'h1234) $display("FAIL rf_discard: got %b/%h want 0/1234", out_InstValid, out_Inst); else passes++;
    endtask

    task automatic test_redirect_accept();
        mem_bus.in_MemReady = 1'b1;
        mem_bus.in_MemData = 16'h5555;
        tick();
        mem_bus.in_MemReady = 1'b0;
        in_InstAccept = 1'b1;
        in_Redirect = 1'b1;
        in_RedirectPC = 16'h0100;
        settle();
        checks++; if (out_InstValid !== 1'b1 || out_Inst !== 16'h5555) $display("FAIL ra_valid: got %b/%h want 1/5555", out_InstValid, out_Inst); else passes++;
        checks++; if (out_IRWrite !== 1'b0) $display("FAIL ra_irwrite: got %b want 0", out_IRWrite); else passes++;
        tick();
        in_InstAccept = 1'b0;
        in_Redirect = 1'b0;
        settle();
        checks++; if (out_FetchCount !== 16'd4) $display("FAIL ra_count: got %0d want 4", out_FetchCount); else passes++;
        checks++; if (mem_bus.out_MemReq !== 1'b1 || mem_bus.out_MemAddr !== 16'h0100) $display("FAIL ra_addr: got %b/%h want 1/0100", mem_bus.out_MemReq, mem_bus.out_MemAddr); else passes++;
    endtask

    task automatic test_pc_wrap();
        in_Redirect = 1'b1;
        in_RedirectPC = 16'hFFFE;
        mem_bus.in_MemReady = 1'b1;
        mem_bus.in_MemData = 16'hBEEF;
        tick();
        in_Redirect = 1'b0;
        mem_bus.in_MemReady = 1'b0;
        settle();
        checks++; if (mem_bus.out_MemReq !== 1'b1 || mem_bus.out_MemAddr !== 16'hFFFE) $display("FAIL wrap_fetch_addr: got %b/%h want 1/fffe", mem_bus.out_MemReq, mem_bus.out_MemAddr); else passes++;
        checks++; if (out_InstValid !== 1'b0 || out_Inst !== 16'h5555) $display("FAIL wrap_discard: got %b/%h want 0/5555", out_InstValid, out_Inst); else passes++;
        mem_bus.in_MemReady = 1'b1;
        mem_bus.in_MemData = 16'h7777;
        tick();
        mem_bus.in_MemReady = 1'b0;
        in_InstAccept = 1'b1;
        settle();
        checks++; if (out_Inst !== 16'h7777 || out_PC !== 16'hFFFE) $display("FAIL wrap_valid: got %h/%h want 7777/fffe", out_Inst, out_PC); else passes++;
        tick();
        in_InstAccept = 1'b0;
        settle();
        checks++; if (mem_bus.out_MemAddr !== 16'h0000) $display("FAIL wrap_addr: got %h want 0000", mem_bus.out_MemAddr); else passes++;
        checks++; if (out_FetchCount !== 16'd5) $display("FAIL wrap_count: got %0d want 5", out_FetchCount); else passes++;
    endtask

    task automatic test_reset_mid_fetch();
        RST = 1'b0;
        settle();
        checks++; if (mem_bus.out_MemReq !== 1'b0 || out_PC !== 16'h0000 || out_FetchCount !== 16'd0) $display("FAIL async_reset: got %b/%h/%0d want 0/0000/0", mem_bus.out_MemReq, out_PC, out_FetchCount); else passes++;
        checks++; if (out_Inst !== 16'h0000) $display("FAIL async_reset_inst: got %h want 0000", out_Inst); else passes++;
        tick();
        RST = 1'b1;
    endtask

    task automatic test_timeout();
        rst2 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (mem_bus2.out_MemReq !== 1'b1 || err2 !== 1'b0) $display("FAIL to_wait%0d: got req %b err %b want 1/0", i, mem_bus2.out_MemReq, err2); else passes++;
            tick();
        end
        checks++; if (err2 !== 1'b1) $display("FAIL to_err: got %b want 1", err2); else passes++;
        checks++; if (mem_bus2.out_MemReq !== 1'b0 || valid2 !== 1'b0) $display("FAIL to_err_outputs: got req %b valid %b want 0/0", mem_bus2.out_MemReq, valid2); else passes++;
        mem_bus2.in_MemReady = 1'b1;
        mem_bus2.in_MemData = 16'h4321;
        tick();
        tick();
        checks++; if (err2 !== 1'b1 || mem_bus2.out_MemReq !== 1'b0 || valid2 !== 1'b0) $display("FAIL to_sticky: got err %b req %b valid %b want 1/0/0", err2, mem_bus2.out_MemReq, valid2); else passes++;
        rst2 = 1'b0;
        settle();
        checks++; if (err2 !== 1'b0) $display("FAIL to_clear: got %b want 0", err2); else passes++;
        mem_bus2.in_MemReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_wait_hold();
        test_redirect_fetch();
        test_redirect_accept();
        test_pc_wrap();
        test_reset_mid_fetch();
        test_timeout();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
